// File: rtl/aq_djpeg_use_ctrl_if.sv
// Consume-interface bundle between the JPEG use controller and its clients/shift register.
// Pure wiring, no latency of its own.
// Backpressure: requests are held by the clients until their grant pulse is seen.
interface aq_djpeg_use_ctrl_if;
   // frame control and shift-register status
   logic       Start;
   logic       Abort;
   logic       DataOutEnable;
   logic       DataOutEnd;
   // client requests
   logic       HdrReqByte;
   logic       HdrReqWord;
   logic       HdrDone;
   logic       HufReq;
   logic [6:0] HufWidth;
   logic       RstReq;
   // grants back to the clients
   logic       HdrGrant;
   logic       HufGrant;
   logic       RstGrant;
   // consume commands to the shift register
   logic       UseBit;
   logic [6:0] UseWidth;
   logic       UseByte;
   logic       UseWord;
   logic       AlignByte;
   // phase / status
   logic       ImageEnable;
   logic       ProcessIdle;
   logic       FrameDone;
   logic       WidthErr;

   // controller side
   modport master (
      input  Start, Abort, DataOutEnable, DataOutEnd,
      input  HdrReqByte, HdrReqWord, HdrDone, HufReq, HufWidth, RstReq,
      output HdrGrant, HufGrant, RstGrant,
      output UseBit, UseWidth, UseByte, UseWord, AlignByte,
      output ImageEnable, ProcessIdle, FrameDone, WidthErr
   );

   // client / shift-register side
   modport slave (
      output Start, Abort, DataOutEnable, DataOutEnd,
      output HdrReqByte, HdrReqWord, HdrDone, HufReq, HufWidth, RstReq,
      input  HdrGrant, HufGrant, RstGrant,
      input  UseBit, UseWidth, UseByte, UseWord, AlignByte,
      input  ImageEnable, ProcessIdle, FrameDone, WidthErr
   );
endinterface

// File: rtl/aq_djpeg_use_ctrl.sv
// Frame sequencer and consume arbiter for the JPEG bitstream shift register.
// Latency: one cycle from arbitration decision to registered Use*/grant pulse.
// Backpressure: no slot while DataOutEnable is low or the post-consume hold-off runs.
module aq_djpeg_use_ctrl #(
   parameter int HOLDOFF  = 2,
   parameter int MAX_BITS = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   aq_djpeg_use_ctrl_if.master  bus
);

   typedef enum logic [1:0] {IDLE, HDR, IMG, DONE} state_t;

   state_t     state;
   logic [1:0] holdCnt;

   logic slotOpen;
   logic hufWidthOk;
   logic issueWord;
   logic issueByte;
   logic issueAlign;
   logic issueBit;
   logic issueAny;
   logic widthBad;
   logic inFlight;

   // Arbitration decision for this cycle: phase-filtered requests, fixed priority.
   always_comb begin
      slotOpen   = bus.DataOutEnable && (holdCnt == 2'd0);
      hufWidthOk = (bus.HufWidth != 7'd0) && (bus.HufWidth <= 7'(MAX_BITS));
      issueWord  = 1'b0;
      issueByte  = 1'b0;
      issueAlign = 1'b0;
      issueBit   = 1'b0;
      widthBad   = 1'b0;
      if (slotOpen && state == HDR) begin
         issueWord = bus.HdrReqWord;
         issueByte = !bus.HdrReqWord && bus.HdrReqByte;
      end
      if (slotOpen && state == IMG) begin
         issueAlign = bus.RstReq;
         issueBit   = !bus.RstReq && bus.HufReq && hufWidthOk;
         // a bad width is flagged whenever it reaches a slot, even if alignment wins
         widthBad   = bus.HufReq && !hufWidthOk;
      end
      issueAny = issueWord || issueByte || issueAlign || issueBit;
      // a consume decided now or still on the outputs keeps the frame from closing
      inFlight = issueAny || bus.UseBit || bus.UseByte || bus.UseWord || bus.AlignByte;
   end

   // Phase FSM with registered consume pulses, grants and status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         holdCnt         <= 2'd0;
         bus.HdrGrant    <= 1'b0;
         bus.HufGrant    <= 1'b0;
         bus.RstGrant    <= 1'b0;
         bus.UseBit      <= 1'b0;
         bus.UseWidth    <= 7'd0;
         bus.UseByte     <= 1'b0;
         bus.UseWord     <= 1'b0;
         bus.AlignByte   <= 1'b0;
         bus.ImageEnable <= 1'b0;
         bus.ProcessIdle <= 1'b1;
         bus.FrameDone   <= 1'b0;
         bus.WidthErr    <= 1'b0;
      end else begin
         // pulses default low; only a decision this cycle raises one
         bus.HdrGrant  <= 1'b0;
         bus.HufGrant  <= 1'b0;
         bus.RstGrant  <= 1'b0;
         bus.UseBit    <= 1'b0;
         bus.UseByte   <= 1'b0;
         bus.UseWord   <= 1'b0;
         bus.AlignByte <= 1'b0;
         bus.FrameDone <= 1'b0;
         if (bus.Abort) begin
            // abort wins over everything, including a decision made this cycle
            state           <= IDLE;
            holdCnt         <= 2'd0;
            bus.ImageEnable <= 1'b0;
            bus.ProcessIdle <= 1'b1;
         end else begin
            if (issueAny)
               holdCnt <= 2'(HOLDOFF);
            else if (holdCnt != 2'd0)
               holdCnt <= holdCnt - 2'd1;

            bus.UseWord   <= issueWord;
            bus.UseByte   <= issueByte;
            bus.AlignByte <= issueAlign;
            bus.UseBit    <= issueBit;
            bus.HdrGrant  <= issueWord || issueByte;
            bus.RstGrant  <= issueAlign;
            bus.HufGrant  <= issueBit;
            if (issueBit)
               bus.UseWidth <= bus.HufWidth;
            if (widthBad)
               bus.WidthErr <= 1'b1;

            case (state)
               IDLE: begin
                  if (bus.Start) begin
                     state           <= HDR;
                     bus.ProcessIdle <= 1'b0;
                     bus.WidthErr    <= 1'b0;
                  end
               end
               HDR: begin
                  // a header grant decided in the same cycle still goes out
                  if (bus.HdrDone) begin
                     state           <= IMG;
                     bus.ImageEnable <= 1'b1;
                  end
               end
               IMG: begin
                  if (bus.DataOutEnd && !inFlight) begin
                     state           <= DONE;
                     bus.ImageEnable <= 1'b0;
                     bus.ProcessIdle <= 1'b1;
                     bus.FrameDone   <= 1'b1;
                  end
               end
               DONE: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_aq_djpeg_use_ctrl.sv
// Self-checking bench for aq_djpeg_use_ctrl: per-cycle vector table plus a
// handshaking Huffman-client frame; every consume pulse is checked against a
// queue of expected consumes filled in as stimulus is driven.
module tb_aq_djpeg_use_ctrl;

   localparam int HOLDOFF = 2;

   localparam logic [2:0] K0 = 3'd0;   // no consume
   localparam logic [2:0] KW = 3'd1;   // UseWord
   localparam logic [2:0] KB = 3'd2;   // UseByte
   localparam logic [2:0] KA = 3'd3;   // AlignByte
   localparam logic [2:0] KU = 3'd4;   // UseBit
   localparam logic [2:0] KX = 3'd7;   // more than one consume at once

   typedef struct {
      logic       start, abort, doe, doEnd, hByte, hWord, hDone, hufReq;
      logic [6:0] width;
      logic       rstReq;
      logic [2:0] kind;
      logic       imgEn, pIdle, fDone, wErr;
   } vec_t;

   typedef struct {
      logic [2:0] kind;
      logic [6:0] width;
   } sb_t;

   logic clk;
   logic rst;

   aq_djpeg_use_ctrl_if u_if ();

   aq_djpeg_use_ctrl #(.HOLDOFF(HOLDOFF), .MAX_BITS(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   int   nVec = 0;
   int   nErr = 0;
   int   cycle = 0;
   vec_t tbl[$];
   sb_t  sbQ[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // hard stop in case a bounded loop is ever broken
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic s, a, e, n, b, w, d, h, input logic [6:0] wid,
                               input logic r, input logic [2:0] k,
                               input logic img, pid, fd, we);
      vec_t v;
      v.start = s; v.abort = a; v.doe = e; v.doEnd = n; v.hByte = b; v.hWord = w;
      v.hDone = d; v.hufReq = h; v.width = wid; v.rstReq = r; v.kind = k;
      v.imgEn = img; v.pIdle = pid; v.fDone = fd; v.wErr = we;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      u_if.Start         = v.start;
      u_if.Abort         = v.abort;
      u_if.DataOutEnable = v.doe;
      u_if.DataOutEnd    = v.doEnd;
      u_if.HdrReqByte    = v.hByte;
      u_if.HdrReqWord    = v.hWord;
      u_if.HdrDone       = v.hDone;
      u_if.HufReq        = v.hufReq;
      u_if.HufWidth      = v.width;
      u_if.RstReq        = v.rstReq;
   endtask

   // advance one clock, sample 1 time unit later and score any consume pulse
   task automatic stepCheck(output logic [2:0] k);
      logic [2:0] g;
      logic [2:0] eg;
      int         nUse;
      sb_t        e;
      @(posedge clk);
      #1;
      cycle++;
      nUse = int'(u_if.UseWord) + int'(u_if.UseByte) + int'(u_if.AlignByte) + int'(u_if.UseBit);
      if (nUse > 1)          k = KX;
      else if (u_if.UseWord) k = KW;
      else if (u_if.UseByte) k = KB;
      else if (u_if.AlignByte) k = KA;
      else if (u_if.UseBit)  k = KU;
      else                   k = K0;
      g = {u_if.HdrGrant, u_if.HufGrant, u_if.RstGrant};
      if (k != K0 || g != 3'b000) begin
         nVec++;
         if (sbQ.size() == 0) begin
            nErr++;
            $display("FAIL unexpected_pulse cycle %0d: kind %0d grants %b, required no pulse", cycle, k, g);
         end else begin
            e  = sbQ.pop_front();
            eg = (e.kind == KW || e.kind == KB) ? 3'b100 : (e.kind == KA) ? 3'b001 : 3'b010;
            if (k != e.kind || g != eg || (e.kind == KU && u_if.UseWidth != e.width)) begin
               nErr++;
               $display("FAIL scoreboard cycle %0d: kind %0d grants %b width %0d, required kind %0d grants %b width %0d",
                        cycle, k, g, u_if.UseWidth, e.kind, eg, e.width);
            end
         end
      end
   endtask

   initial begin
      logic [2:0] k;
      logic [6:0] widths[4];
      int         lastGrant;
      int         budget;
      sb_t        e;
      vec_t       z;

      //         S  A  E  N  B  W  D  H  wid    R  kind img idle done werr
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 7'd0,  0, K0, 0, 0, 0, 0)); // 0 start
      tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 7'd0,  0, KW, 0, 0, 0, 0)); // 1 word beats byte
      tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 7'd0,  0, K0, 0, 0, 0, 0)); // 2 held, hold-off
      tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 7'd0,  0, K0, 0, 0, 0, 0)); // 3
      tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 7'd0,  0, KB, 0, 0, 0, 0)); // 4 1+HOLDOFF later
      tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1, 7'd5,  1, K0, 0, 0, 0, 0)); // 5
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 7'd5,  1, K0, 0, 0, 0, 0)); // 6 end ignored in HDR
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 7'd5,  1, K0, 0, 0, 0, 0)); // 7 huf/rst ignored in HDR
      tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, 7'd0,  0, KW, 1, 0, 0, 0)); // 8 grant + HdrDone
      tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1, 7'd9,  1, K0, 1, 0, 0, 0)); // 9
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 7'd9,  1, K0, 1, 0, 0, 0)); // 10
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 7'd9,  1, KA, 1, 0, 0, 0)); // 11 align beats huf
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 7'd9,  1, K0, 1, 0, 0, 0)); // 12
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 7'd9,  0, K0, 1, 0, 0, 0)); // 13
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 7'd9,  0, KU, 1, 0, 0, 0)); // 14 UseBit 9
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 7'd9,  0, K0, 1, 0, 0, 0)); // 15
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 7'd0,  0, K0, 1, 0, 0, 0)); // 16
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 7'd0,  0, K0, 1, 0, 0, 1)); // 17 width 0 -> err
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 7'd33, 0, K0, 1, 0, 0, 1)); // 18 width 33 -> err
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 7'd32, 0, KU, 1, 0, 0, 1)); // 19 width 32 issued
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 7'd32, 0, K0, 1, 0, 0, 1)); // 20
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7'd3,  1, K0, 1, 0, 0, 1)); // 21 no data valid
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7'd3,  1, K0, 1, 0, 0, 1)); // 22
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7'd3,  1, K0, 1, 0, 0, 1)); // 23
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 7'd3,  1, KA, 1, 0, 0, 1)); // 24 valid rises
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 7'd3,  1, K0, 1, 0, 0, 1)); // 25
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 7'd3,  0, K0, 1, 0, 0, 1)); // 26
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7'd3,  0, K0, 1, 0, 0, 1)); // 27 valid low at slot
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 7'd3,  0, KU, 1, 0, 0, 1)); // 28
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 7'd3,  0, K0, 1, 0, 0, 1)); // 29 end, pulse in flight
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 7'd0,  0, K0, 0, 1, 1, 1)); // 30 -> DONE
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7'd0,  0, K0, 0, 1, 0, 1)); // 31 -> IDLE
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 7'd0,  0, K0, 0, 1, 0, 1)); // 32 start with abort
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 7'd0,  0, K0, 0, 0, 0, 0)); // 33 start clears err
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 7'd0,  0, K0, 1, 0, 0, 0)); // 34 -> IMG
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 7'd7,  0, K0, 0, 1, 0, 0)); // 35 abort at decision
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 7'd0,  0, K0, 0, 1, 0, 0)); // 36 stays idle

      z = mk(0, 0, 0, 0, 0, 0, 0, 0, 7'd0, 0, K0, 0, 0, 0, 0);
      drive(z);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      nVec++;
      if ({u_if.HdrGrant, u_if.HufGrant, u_if.RstGrant, u_if.UseBit, u_if.UseByte, u_if.UseWord,
           u_if.AlignByte, u_if.ImageEnable, u_if.FrameDone, u_if.WidthErr} != 10'd0 ||
          u_if.UseWidth != 7'd0 || u_if.ProcessIdle != 1'b1) begin
         nErr++;
         $display("FAIL reset: pulses/flags %b width %0d idle %0b, required all 0, width 0, idle 1",
                  {u_if.HdrGrant, u_if.HufGrant, u_if.RstGrant, u_if.UseBit, u_if.UseByte, u_if.UseWord,
                   u_if.AlignByte, u_if.ImageEnable, u_if.FrameDone, u_if.WidthErr},
                  u_if.UseWidth, u_if.ProcessIdle);
      end
      rst = 1'b1;

      // cycle-by-cycle table
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         if (tbl[i].kind != K0) begin
            e.kind  = tbl[i].kind;
            e.width = tbl[i].width;
            sbQ.push_back(e);
         end
         stepCheck(k);
         nVec++;
         if (k != tbl[i].kind || u_if.ImageEnable != tbl[i].imgEn || u_if.ProcessIdle != tbl[i].pIdle ||
             u_if.FrameDone != tbl[i].fDone || u_if.WidthErr != tbl[i].wErr) begin
            nErr++;
            $display("FAIL vec%0d: kind %0d img %0b idle %0b done %0b werr %0b, required kind %0d img %0b idle %0b done %0b werr %0b",
                     i, k, u_if.ImageEnable, u_if.ProcessIdle, u_if.FrameDone, u_if.WidthErr,
                     tbl[i].kind, tbl[i].imgEn, tbl[i].pIdle, tbl[i].fDone, tbl[i].wErr);
         end
      end

      // full frame with a Huffman client that holds until granted and drops the cycle after
      drive(z);
      u_if.Start = 1'b1;
      stepCheck(k);
      u_if.Start         = 1'b0;
      u_if.DataOutEnable = 1'b1;
      u_if.HdrDone       = 1'b1;
      stepCheck(k);
      u_if.HdrDone = 1'b0;
      widths[0] = 7'd1; widths[1] = 7'd12; widths[2] = 7'd27; widths[3] = 7'd32;
      lastGrant = 0;
      for (int n = 0; n < 4; n++) begin
         u_if.HufReq   = 1'b1;
         u_if.HufWidth = widths[n];
         e.kind  = KU;
         e.width = widths[n];
         sbQ.push_back(e);
         budget = 0;
         do begin
            stepCheck(k);
            budget++;
         end while (!u_if.HufGrant && budget < 10);
         nVec++;
         if (!u_if.HufGrant) begin
            nErr++;
            $display("FAIL huf_grant_timeout req%0d: no grant in %0d cycles, required grant", n, budget);
         end else if (n > 0 && cycle - lastGrant != 1 + HOLDOFF) begin
            nErr++;
            $display("FAIL huf_grant_gap req%0d: gap %0d cycles, required %0d", n, cycle - lastGrant, 1 + HOLDOFF);
         end
         lastGrant = cycle;
         stepCheck(k);
         u_if.HufReq = 1'b0;
         stepCheck(k);
      end
      u_if.DataOutEnd = 1'b1;
      budget = 0;
      do begin
         stepCheck(k);
         budget++;
      end while (!u_if.FrameDone && budget < 8);
      nVec++;
      if (!u_if.FrameDone || !u_if.ProcessIdle || u_if.ImageEnable) begin
         nErr++;
         $display("FAIL frame_done: done %0b idle %0b img %0b after %0d cycles, required done 1 idle 1 img 0",
                  u_if.FrameDone, u_if.ProcessIdle, u_if.ImageEnable, budget);
      end
      u_if.DataOutEnd = 1'b0;
      stepCheck(k);
      nVec++;
      if (u_if.FrameDone || !u_if.ProcessIdle || u_if.ImageEnable) begin
         nErr++;
         $display("FAIL after_done: done %0b idle %0b img %0b, required done 0 idle 1 img 0",
                  u_if.FrameDone, u_if.ProcessIdle, u_if.ImageEnable);
      end

      nVec++;
      if (sbQ.size() != 0) begin
         nErr++;
         $display("FAIL scoreboard_drain: %0d consumes never issued, required 0", sbQ.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
